// File: rtl/hs_bus_arbiter.sv
// -----------------------------------------------------------------------------
// hs_bus_arbiter
//
// Shares the 005885 work RAM between the main MC6809E and the MiSTer hiscore
// port. A hiscore request waits for vertical blank, halts the CPU through
// nHALT, waits for the bus-available acknowledge and then grants the hiscore
// module exclusive RAM access. The user pause is merged onto the same nHALT
// line.
//
// Parameters
//   ACK_TIMEOUT  clk_49m cycles allowed in HALT for BA to be qualified
//   MAX_GRANT    longest single grant, in clk_49m cycles
//   GUARD        cycles nHALT stays asserted after the grant drops (>= 1)
//
// Ports
//   clk_49m        in   system clock, 49.152 MHz
//   reset          in   synchronous, active-high
//   n_pause        in   user pause, active-low
//   hs_req         in   hiscore RAM request, level
//   vblank         in   005885 VBLK
//   cpu_ba         in   MC6809E bus-available, asynchronous
//   cpu_n_halt     out  MC6809E nHALT (registered)
//   hs_grant       out  005885 hs_access; hiscore may drive the RAM only
//                       while this is high (registered)
//   busy           out  FSM not idle
//   ack_timeout    out  sticky: BA never qualified within ACK_TIMEOUT
//   grant_overrun  out  sticky: a grant reached MAX_GRANT
// -----------------------------------------------------------------------------
module hs_bus_arbiter #(
   parameter int unsigned ACK_TIMEOUT = 4096,
   parameter int unsigned MAX_GRANT   = 65535,
   parameter int unsigned GUARD       = 8
) (
   input  logic clk_49m,
   input  logic reset,
   input  logic n_pause,
   input  logic hs_req,
   input  logic vblank,
   input  logic cpu_ba,
   output logic cpu_n_halt,
   output logic hs_grant,
   output logic busy,
   output logic ack_timeout,
   output logic grant_overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_VBL,
      S_HALT,
      S_GRANT,
      S_RELEASE
   } state_e;

   localparam int CW = 17;
   localparam logic [CW-1:0] CNT_MAX    = '1;
   localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] GRANT_LAST = CW'(MAX_GRANT - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            armed_q, armed_d;
   logic            ack_to_q, ack_to_d;
   logic            ovr_q, ovr_d;
   logic            n_halt_q;
   logic            grant_q;

   // BA synchroniser (meta -> sync) plus one qualifying stage (prev).
   logic            ba_meta_q, ba_sync_q, ba_prev_q;
   logic            ba_en;
   logic            ba_ok;
   logic            halt_fsm;

   // Saturating cycle counter shared by HALT, GRANT and RELEASE.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

   // BA must be seen high on two consecutive synchronised samples.
   assign ba_ok = ba_sync_q & ba_prev_q;

   // The BA pipeline only runs while the FSM is (about to be) halting or
   // granting; it is flushed otherwise, so every halt re-qualifies BA from
   // scratch even if the CPU was already stopped by the user pause.
   assign ba_en = (state_d == S_HALT) || (state_d == S_GRANT);

   assign halt_fsm = (state_q == S_HALT) || (state_q == S_GRANT) ||
                     (state_q == S_RELEASE);

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_inc;
      armed_d  = armed_q;
      ack_to_d = ack_to_q;
      ovr_d    = ovr_q;

      // Any cycle without a request re-arms the block.
      if (!hs_req) armed_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (hs_req && armed_q) state_d = S_WAIT_VBL;
         end

         S_WAIT_VBL: begin
            cnt_d = '0;
            if (!hs_req)     state_d = S_IDLE;
            else if (vblank) state_d = S_HALT;
         end

         S_HALT: begin
            // The CPU is already being halted, so a withdrawn request still
            // goes through RELEASE to give the bus its guard time.
            if (!hs_req) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
            end else if (ba_ok) begin
               state_d = S_GRANT;
               cnt_d   = '0;
            end else if (cnt_q == ACK_LAST) begin
               ack_to_d = 1'b1;
               state_d  = S_RELEASE;
               cnt_d    = '0;
            end
         end

         S_GRANT: begin
            // A BA glitch ends the grant silently: the hiscore port must
            // never drive the RAM while the CPU may own the bus.
            if (!hs_req || !ba_sync_q) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == GRANT_LAST) begin
               ovr_d   = 1'b1;
               state_d = S_RELEASE;
               cnt_d   = '0;
            end
         end

         S_RELEASE: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               // A request still held here is stale; wait for it to drop.
               if (hs_req) armed_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk_49m) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         armed_q   <= 1'b1;
         ack_to_q  <= 1'b0;
         ovr_q     <= 1'b0;
         n_halt_q  <= 1'b1;
         grant_q   <= 1'b0;
         ba_meta_q <= 1'b0;
         ba_sync_q <= 1'b0;
         ba_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         ack_to_q  <= ack_to_d;
         ovr_q     <= ovr_d;
         n_halt_q  <= n_pause & ~halt_fsm;
         // Raised the cycle after GRANT entry; dropped on the very edge the
         // FSM leaves GRANT so the hiscore port loses the bus immediately.
         grant_q   <= (state_q == S_GRANT) && (state_d == S_GRANT);
         ba_meta_q <= ba_en & cpu_ba;
         ba_sync_q <= ba_en & ba_meta_q;
         ba_prev_q <= ba_en & ba_sync_q;
      end
   end

   assign cpu_n_halt    = n_halt_q;
   assign hs_grant      = grant_q;
   assign busy          = (state_q != S_IDLE);
   assign ack_timeout   = ack_to_q;
   assign grant_overrun = ovr_q;

endmodule
